// File: rtl/iencoder_loader.sv
// iencoder_loader: accepts decoded instruction field tuples, re-encodes each
// into a 32-bit instruction word, and streams the words into instruction
// memory through a one-deep output register with a valid/ready write port.
module iencoder_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        cond,
  input  logic [6:0]        opcode,
  input  logic              en_status,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [3:0]        rs,
  input  logic [3:0]        rm,
  input  logic [1:0]        shift_op,
  input  logic [4:0]        imm5,
  input  logic [11:0]       imm12,
  input  logic [23:0]       imm24,
  input  logic              P,
  input  logic              U,
  input  logic              W,
  output logic              mem_wr,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic [ADDR_W-1:0] wr_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0] wr_count_q;
  logic              wr_q;
  logic [31:0]       wdata_q;
  logic              err_q;

  logic              enc_legal;
  logic [31:0]       enc_word;
  logic [3:0]        alu;
  logic              s_bit;
  logic              ls_i;
  logic              ls_l;
  logic [3:0]        ls_rn;
  logic              accept;
  logic              wr_done;
  logic              start_ok;

  // The opcode's low three bits always supply P/U/W, so the ports are
  // carried for interface compatibility only.
  logic unused_puw;
  assign unused_puw = ^{P, U, W};

  assign accept   = in_valid && in_ready;
  assign wr_done  = wr_q && mem_ready;
  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

  // Combinational encoder: maps the field tuple to a word and flags illegal opcodes.
  always_comb begin
    enc_legal = 1'b0;
    enc_word  = 32'h0;
    alu       = 4'h0;
    s_bit     = 1'b0;
    ls_i      = 1'b0;
    ls_l      = 1'b0;
    ls_rn     = rn;
    if (opcode == 7'b0000000) begin
      enc_legal = 1'b1;
      enc_word  = {cond, 28'h3200000};
    end else if (opcode == 7'b0000001) begin
      enc_legal = 1'b1;
      enc_word  = {cond, 28'h1000000};
    end else if (!opcode[6] && opcode[3]) begin
      case (opcode[2:0])
        3'b000:  alu = 4'b0100;
        3'b001:  alu = 4'b0010;
        3'b010:  alu = 4'b1010;
        3'b011:  alu = 4'b0000;
        3'b100:  alu = 4'b1100;
        3'b101:  alu = 4'b0001;
        3'b110:  alu = 4'b1101;
        default: alu = 4'b1111;
      endcase
      // CMP only exists to set flags, so S is forced for it.
      s_bit = en_status | (opcode[2:0] == 3'b010);
      case (opcode[5:4])
        2'b00: begin
          enc_legal = 1'b1;
          enc_word  = {cond, 2'b00, 1'b1, alu, s_bit, rn, rd, imm12};
        end
        2'b01: begin
          enc_legal = 1'b1;
          enc_word  = {cond, 2'b00, 1'b0, alu, s_bit, rn, rd, imm5, shift_op, 1'b0, rm};
        end
        2'b11: begin
          enc_legal = 1'b1;
          enc_word  = {cond, 2'b00, 1'b0, alu, s_bit, rn, rd, rs, 1'b0, shift_op, 1'b1, rm};
        end
        default: enc_legal = 1'b0;
      endcase
    end else if (opcode == 7'b1000000) begin
      enc_legal = 1'b1;
      enc_word  = {cond, 4'b1010, imm24};
    end else if (opcode[6]) begin
      case (opcode[5:3])
        3'b001: begin
          enc_legal = 1'b1;
          ls_l      = 1'b1;
          ls_rn     = 4'hF;
        end
        3'b100: begin
          enc_legal = 1'b1;
          ls_l      = 1'b1;
        end
        3'b101: begin
          enc_legal = 1'b1;
          ls_i      = 1'b1;
          ls_l      = 1'b1;
        end
        3'b110: begin
          enc_legal = 1'b1;
        end
        3'b111: begin
          enc_legal = 1'b1;
          ls_i      = 1'b1;
        end
        default: enc_legal = 1'b0;
      endcase
      enc_word = {cond, 2'b01, ls_i, opcode[2], opcode[1], 1'b0, opcode[0], ls_l,
                  ls_rn, rd, (ls_i ? {imm5, shift_op, 1'b0, rm} : imm12)};
    end
  end

  // Session sequencing: next state and accepted-tuple count.
  always_comb begin
    state_d = state_q;
    acc_d   = accept ? acc_q + 1'b1 : acc_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (acc_d == count_q) state_d = DRAIN;
      DRAIN:   if (!wr_q) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Session bookkeeping, output register and write-address tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q     <= '0;
      count_q    <= '0;
      acc_q      <= '0;
      wr_count_q <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q     <= base_addr;
        count_q    <= count;
        acc_q      <= '0;
        wr_count_q <= '0;
        err_q      <= 1'b0;
      end else begin
        acc_q <= acc_d;
        if (accept && !enc_legal) err_q <= 1'b1;
        if (wr_done) begin
          addr_q     <= addr_q + 1'b1;
          wr_count_q <= wr_count_q + 1'b1;
        end
      end
      if (accept && enc_legal) begin
        wr_q    <= 1'b1;
        wdata_q <= enc_word;
      end else if (wr_done) begin
        wr_q <= 1'b0;
      end
    end
  end

  assign in_ready    = (state_q == RUN) && (acc_q < count_q) && (!wr_q || mem_ready);
  assign mem_wr      = wr_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign busy        = (state_q == RUN) || (state_q == DRAIN);
  assign done        = (state_q == DONE);
  assign err_illegal = err_q;
  assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_iencoder_loader.sv
// Directed testbench for iencoder_loader with hand-computed instruction words.
module tb_iencoder_loader;
  localparam int AW = 10;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] count;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    cond;
  logic [6:0]    opcode;
  logic          en_status;
  logic [3:0]    rn, rd, rs, rm;
  logic [1:0]    shift_op;
  logic [4:0]    imm5;
  logic [11:0]   imm12;
  logic [23:0]   imm24;
  logic          P, U, W;
  logic          mem_wr;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          err_illegal;
  logic [AW-1:0] wr_count;

  int n_checks = 0;
  int n_errors = 0;

  iencoder_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .cond(cond), .opcode(opcode),
    .en_status(en_status), .rn(rn), .rd(rd), .rs(rs), .rm(rm), .shift_op(shift_op),
    .imm5(imm5), .imm12(imm12), .imm24(imm24), .P(P), .U(U), .W(W),
    .mem_wr(mem_wr), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err_illegal(err_illegal), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fields();
    in_valid = 1'b0; cond = 4'h0; opcode = 7'h0; en_status = 1'b0;
    rn = 4'h0; rd = 4'h0; rs = 4'h0; rm = 4'h0; shift_op = 2'b00;
    imm5 = 5'h0; imm12 = 12'h0; imm24 = 24'h0; P = 1'b0; U = 1'b0; W = 1'b0;
  endtask

  task automatic set_tuple(input logic [3:0] c, input logic [6:0] op, input logic [3:0] n,
                           input logic [3:0] d, input logic [3:0] s, input logic [3:0] m,
                           input logic [1:0] sh, input logic [4:0] i5, input logic [11:0] i12,
                           input logic [23:0] i24, input logic es);
    cond = c; opcode = op; rn = n; rd = d; rs = s; rm = m; shift_op = sh;
    imm5 = i5; imm12 = i12; imm24 = i24; en_status = es;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] c);
    start = 1'b1; base_addr = b; count = c;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_checks++;
    if ({in_ready, mem_wr, busy, done, err_illegal, mem_addr, mem_wdata, wr_count} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got rdy=%b wr=%b busy=%b done=%b err=%b addr=%h data=%h cnt=%h, required all 0",
               in_ready, mem_wr, busy, done, err_illegal, mem_addr, mem_wdata, wr_count);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({busy, done, in_ready} !== 3'b000) begin
      n_errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b rdy=%b, required 000", busy, done, in_ready);
    end
  endtask

  task automatic test_add_imm();
    bit ok;
    mem_ready = 1'b1;
    do_start(10'h010, 10'd1);
    n_checks++;
    if ({busy, in_ready} !== 2'b11) begin
      n_errors++;
      $display("FAIL add_run: got busy=%b rdy=%b, required 11", busy, in_ready);
    end
    set_tuple(4'hE, 7'b0001000, 4'h1, 4'h2, 4'h0, 4'h0, 2'b00, 5'h0, 12'h005, 24'h0, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({mem_wr, mem_addr, mem_wdata, in_ready} !== {1'b1, 10'h010, 32'hE2812005, 1'b0}) begin
      n_errors++;
      $display("FAIL add_write: got wr=%b addr=%h data=%h rdy=%b, required wr=1 addr=010 data=e2812005 rdy=0",
               mem_wr, mem_addr, mem_wdata, in_ready);
    end
    wait_done(ok);
    n_checks++;
    if (!ok || wr_count !== 10'd1) begin
      n_errors++;
      $display("FAIL add_done: got done_seen=%0d wr_count=%0d, required 1 and 1", ok, wr_count);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_errors++;
      $display("FAIL done_pulse: got done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic test_cmp_reg_reg();
    bit ok;
    mem_ready = 1'b1;
    do_start(10'h030, 10'd1);
    set_tuple(4'h5, 7'b0111010, 4'h5, 4'h5, 4'h5, 4'h5, 2'b10, 5'h0, 12'h0, 24'h0, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({mem_wr, mem_wdata} !== {1'b1, 32'h51555555}) begin
      n_errors++;
      $display("FAIL cmp_data: got wr=%b data=%h, required wr=1 data=51555555", mem_wr, mem_wdata);
    end
    wait_done(ok);
  endtask

  task automatic test_ldr_str();
    bit ok;
    mem_ready = 1'b1;
    do_start(10'h040, 10'd2);
    set_tuple(4'hE, 7'b1001111, 4'h3, 4'h0, 4'h0, 4'h0, 2'b00, 5'h0, 12'h000, 24'h0, 1'b0);
    P = 1'b0; U = 1'b0; W = 1'b0;
    in_valid = 1'b1;
    tick();
    n_checks++;
    if ({mem_addr, mem_wdata} !== {10'h040, 32'hE5BF0000}) begin
      n_errors++;
      $display("FAIL ldr_literal: got addr=%h data=%h, required 040 e5bf0000", mem_addr, mem_wdata);
    end
    set_tuple(4'hE, 7'b1111011, 4'hA, 4'h0, 4'h0, 4'h0, 2'b00, 5'h0, 12'h000, 24'h0, 1'b0);
    P = 1'b1; U = 1'b0; W = 1'b0;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({mem_addr, mem_wdata} !== {10'h041, 32'hE6AA0000}) begin
      n_errors++;
      $display("FAIL str_reg: got addr=%h data=%h, required 041 e6aa0000", mem_addr, mem_wdata);
    end
    wait_done(ok);
    n_checks++;
    if (!ok || wr_count !== 10'd2) begin
      n_errors++;
      $display("FAIL ldr_str_done: got done_seen=%0d wr_count=%0d, required 1 and 2", ok, wr_count);
    end
    clear_fields();
  endtask

  task automatic test_stall();
    bit ok;
    mem_ready = 1'b0;
    do_start(10'h100, 10'd3);
    set_tuple(4'hE, 7'b0001110, 4'h0, 4'h1, 4'h0, 4'h0, 2'b00, 5'h0, 12'h0AB, 24'h0, 1'b0);
    in_valid = 1'b1;
    tick();
    set_tuple(4'hE, 7'b0011100, 4'h2, 4'h3, 4'h0, 4'h5, 2'b01, 5'h04, 12'h0, 24'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({in_ready, mem_wr, mem_addr, mem_wdata} !== {1'b0, 1'b1, 10'h100, 32'hE3A010AB}) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: got rdy=%b wr=%b addr=%h data=%h, required 0 1 100 e3a010ab",
                 k, in_ready, mem_wr, mem_addr, mem_wdata);
      end
      if (k == 1) begin
        start = 1'b1; base_addr = 10'h200; count = 10'd5;
      end
      tick();
      start = 1'b0;
    end
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_release_ready: got rdy=%b, required 1", in_ready);
    end
    tick();
    n_checks++;
    if ({mem_addr, mem_wdata, wr_count} !== {10'h101, 32'hE1923225, 10'd1}) begin
      n_errors++;
      $display("FAIL stall_second: got addr=%h data=%h cnt=%0d, required 101 e1923225 1",
               mem_addr, mem_wdata, wr_count);
    end
    set_tuple(4'h0, 7'b0001101, 4'h4, 4'h4, 4'h0, 4'h0, 2'b00, 5'h0, 12'hFFF, 24'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({in_ready, mem_addr, mem_wdata} !== {1'b0, 10'h102, 32'h02244FFF}) begin
      n_errors++;
      $display("FAIL stall_third: got rdy=%b addr=%h data=%h, required 0 102 02244fff",
               in_ready, mem_addr, mem_wdata);
    end
    tick();
    n_checks++;
    if ({mem_wr, mem_addr, wr_count} !== {1'b0, 10'h103, 10'd3}) begin
      n_errors++;
      $display("FAIL stall_final: got wr=%b addr=%h cnt=%0d, required 0 103 3", mem_wr, mem_addr, wr_count);
    end
    wait_done(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL stall_done: got done_seen=0, required 1");
    end
  endtask

  task automatic test_illegal();
    bit ok;
    mem_ready = 1'b1;
    do_start(10'h020, 10'd2);
    set_tuple(4'hE, 7'b0100000, 4'h1, 4'h1, 4'h0, 4'h0, 2'b00, 5'h0, 12'h0, 24'h0, 1'b0);
    in_valid = 1'b1;
    tick();
    n_checks++;
    if ({mem_wr, err_illegal} !== 2'b01) begin
      n_errors++;
      $display("FAIL illegal_consume: got wr=%b err=%b, required wr=0 err=1", mem_wr, err_illegal);
    end
    set_tuple(4'hE, 7'b0000000, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00, 5'h0, 12'h0, 24'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 10'h020, 32'hE3200000}) begin
      n_errors++;
      $display("FAIL illegal_nop: got wr=%b addr=%h data=%h, required 1 020 e3200000", mem_wr, mem_addr, mem_wdata);
    end
    wait_done(ok);
    n_checks++;
    if (!ok || wr_count !== 10'd1 || err_illegal !== 1'b1) begin
      n_errors++;
      $display("FAIL illegal_done: got done_seen=%0d cnt=%0d err=%b, required 1 1 1", ok, wr_count, err_illegal);
    end
  endtask

  task automatic test_count_zero();
    bit ok;
    bit seen_wr;
    ok = 1'b0;
    seen_wr = 1'b0;
    do_start(10'h050, 10'd0);
    n_checks++;
    if ({busy, in_ready, err_illegal} !== 3'b100) begin
      n_errors++;
      $display("FAIL zero_run: got busy=%b rdy=%b err=%b, required 1 0 0", busy, in_ready, err_illegal);
    end
    for (int k = 0; k < 20; k++) begin
      if (mem_wr === 1'b1) seen_wr = 1'b1;
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!ok || seen_wr || wr_count !== 10'd0) begin
      n_errors++;
      $display("FAIL zero_done: got done_seen=%0d wr_seen=%0d cnt=%0d, required 1 0 0", ok, seen_wr, wr_count);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    mem_ready = 1'b1;
    do_start(10'h060, 10'd1);
    set_tuple(4'h0, 7'b0000000, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00, 5'h0, 12'h0, 24'h0, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (mem_wdata !== 32'h03200000) begin
      n_errors++;
      $display("FAIL b2b_nop: got data=%h, required 03200000", mem_wdata);
    end
    wait_done(ok);
    do_start(10'h070, 10'd1);
    n_checks++;
    if ({busy, wr_count} !== {1'b1, 10'd0}) begin
      n_errors++;
      $display("FAIL b2b_restart: got busy=%b cnt=%0d, required 1 0", busy, wr_count);
    end
    set_tuple(4'h1, 7'b0000001, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00, 5'h0, 12'h0, 24'h0, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({mem_addr, mem_wdata} !== {10'h070, 32'h11000000}) begin
      n_errors++;
      $display("FAIL b2b_halt: got addr=%h data=%h, required 070 11000000", mem_addr, mem_wdata);
    end
    wait_done(ok);
  endtask

  task automatic test_wrap();
    bit ok;
    mem_ready = 1'b1;
    do_start(10'h3FF, 10'd2);
    set_tuple(4'hA, 7'b0000001, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00, 5'h0, 12'h0, 24'h0, 1'b0);
    in_valid = 1'b1;
    tick();
    n_checks++;
    if ({mem_addr, mem_wdata} !== {10'h3FF, 32'hA1000000}) begin
      n_errors++;
      $display("FAIL wrap_top: got addr=%h data=%h, required 3ff a1000000", mem_addr, mem_wdata);
    end
    set_tuple(4'hE, 7'b1000000, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00, 5'h0, 12'h0, 24'h123456, 1'b0);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({mem_addr, mem_wdata} !== {10'h000, 32'hEA123456}) begin
      n_errors++;
      $display("FAIL wrap_zero: got addr=%h data=%h, required 000 ea123456", mem_addr, mem_wdata);
    end
    wait_done(ok);
    n_checks++;
    if (!ok || {wr_count, mem_addr} !== {10'd2, 10'h001}) begin
      n_errors++;
      $display("FAIL wrap_done: got done_seen=%0d cnt=%0d addr=%h, required 1 2 001", ok, wr_count, mem_addr);
    end
  endtask

  task automatic test_reset_mid_stall();
    mem_ready = 1'b0;
    do_start(10'h055, 10'd2);
    set_tuple(4'hE, 7'b0001000, 4'h1, 4'h2, 4'h0, 4'h0, 2'b00, 5'h0, 12'h005, 24'h0, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (mem_wr !== 1'b1) begin
      n_errors++;
      $display("FAIL midstall_pending: got wr=%b, required 1", mem_wr);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({in_ready, mem_wr, busy, done, err_illegal, mem_addr, mem_wdata, wr_count} !== '0) begin
      n_errors++;
      $display("FAIL midstall_reset: got rdy=%b wr=%b busy=%b done=%b err=%b addr=%h data=%h cnt=%h, required all 0",
               in_ready, mem_wr, busy, done, err_illegal, mem_addr, mem_wdata, wr_count);
    end
    rst_n = 1'b1;
    mem_ready = 1'b1;
    tick();
    n_checks++;
    if ({mem_wr, busy, wr_count} !== {1'b0, 1'b0, 10'd0}) begin
      n_errors++;
      $display("FAIL midstall_abandon: got wr=%b busy=%b cnt=%0d, required 0 0 0", mem_wr, busy, wr_count);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    count = '0;
    mem_ready = 1'b0;
    clear_fields();
    test_reset();
    test_add_imm();
    test_cmp_reg_reg();
    test_ldr_str();
    test_stall();
    test_illegal();
    test_count_zero();
    test_back_to_back();
    test_wrap();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
